// File: rtl/div_unit_if.sv
// Handshake and result bundle between the EX-stage requester and div_unit.
// master: requester (drives start/is_signed/a/b/annul, sees stall/ready/results)
// slave : div_unit
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             stall_req;
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, a, b, annul,
    input  stall_req, ready, quotient, remainder
  );

  modport slave (
    input  start, is_signed, a, b, annul,
    output stall_req, ready, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Ports:
//   clk, rst     core clock, asynchronous active-high reset
//   bus (slave)  start/is_signed/a/b/annul in; stall_req (combinational),
//                ready (one-cycle pulse), quotient (LO), remainder (HI) out
// Only WIDTH = 32 is supported (6-bit iteration counter).
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int unsigned CW = 6;
  localparam int unsigned RW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    prem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             sgn_a;
  logic             sgn_b;
  logic             sgn_mode;
  logic             ready_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [RW-1:0]    rem_sh;
  logic [RW-1:0]    diff;
  logic             qbit;
  logic [WIDTH-1:0] q_next;
  logic [RW-1:0]    r_next;
  logic [WIDTH-1:0] r_mag;
  logic             neg_q;
  logic             neg_r;

  // Operand magnitudes; 0x80000000 maps to itself, which is correct unsigned.
  assign abs_a = (bus.is_signed && bus.a[WIDTH-1]) ? WIDTH'(-bus.a) : bus.a;
  assign abs_b = (bus.is_signed && bus.b[WIDTH-1]) ? WIDTH'(-bus.b) : bus.b;

  // One restoring step: the dividend register doubles as the quotient
  // shift register, feeding its MSB into the partial remainder.
  assign rem_sh = RW'({prem, dvd[WIDTH-1]});
  assign diff   = rem_sh - RW'(dvs);
  assign qbit   = ~diff[RW-1];
  assign q_next = {dvd[WIDTH-2:0], qbit};
  assign r_next = qbit ? diff : rem_sh;
  assign r_mag  = WIDTH'(r_next);

  assign neg_q = sgn_mode & (sgn_a ^ sgn_b);
  assign neg_r = sgn_mode & sgn_a;

  // Stall is combinational so the pipeline holds in the request cycle itself.
  assign bus.stall_req = ((state == IDLE) && bus.start && !bus.annul) || (state == RUN);

  // An annul in DONE suppresses the pulse already registered for this cycle.
  assign bus.ready = ready_q && !bus.annul;

  // Control, datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      prem          <= '0;
      dvd           <= '0;
      dvs           <= '0;
      sgn_a         <= 1'b0;
      sgn_b         <= 1'b0;
      sgn_mode      <= 1'b0;
      ready_q       <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.annul) begin
            dvd      <= abs_a;
            dvs      <= abs_b;
            sgn_a    <= bus.a[WIDTH-1];
            sgn_b    <= bus.b[WIDTH-1];
            sgn_mode <= bus.is_signed;
            cnt      <= '0;
            prem     <= '0;
            if (bus.b == '0) begin
              // Divide by zero: fixed result, no sign fix-up.
              state         <= DONE;
              ready_q       <= 1'b1;
              bus.quotient  <= '1;
              bus.remainder <= bus.a;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.annul) begin
            state <= IDLE;
          end else begin
            prem <= r_next;
            dvd  <= q_next;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state         <= DONE;
              ready_q       <= 1'b1;
              bus.quotient  <= neg_q ? WIDTH'(-q_next) : q_next;
              bus.remainder <= neg_r ? WIDTH'(-r_mag) : r_mag;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table of directed vectors, random ops
// against a behavioural model, and hand-written annul/reset sequences.
module tb_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] sb_q[$];
  logic [31:0] sb_r[$];

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          spur;
  } vec_t;

  vec_t vecs[12];

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Runs one division; optionally drives an extra start in cycle 'spur' that
  // must be ignored. Checks stall profile, latency and results.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input int spur,
                       input string tag);
    int lat_exp;
    int lat;
    int stall_bad;
    logic [31:0] pq;
    logic [31:0] pr;
    lat_exp = (b == 32'h0) ? 1 : 33;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.is_signed = sgn; bus.a = a; bus.b = b;
    sb_q.push_back(eq);
    sb_r.push_back(er);
    #3;
    chk({tag, "_stall_c0"}, 32'(bus.stall_req), 32'd1);
    lat = -1;
    stall_bad = 0;
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      bus.start = (cyc == spur);
      if (cyc == spur) begin
        bus.a = 32'd100; bus.b = 32'd7; bus.is_signed = 1'b0;
      end
      #3;
      if (bus.ready) lat = cyc;
      if (bus.stall_req != (cyc < lat_exp)) stall_bad++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_stall_profile_errs"}, 32'(stall_bad), 32'd0);
    pq = sb_q.pop_front();
    pr = sb_r.pop_front();
    chk({tag, "_quotient"}, bus.quotient, pq);
    chk({tag, "_remainder"}, bus.remainder, pr);
    @(posedge clk); #1;
    bus.start = 1'b0;
    #3;
    chk({tag, "_idle_ready"}, 32'(bus.ready), 32'd0);
    chk({tag, "_idle_stall"}, 32'(bus.stall_req), 32'd0);
  endtask

  // Watches for n cycles and returns how many ready pulses were seen.
  task automatic count_ready(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #4;
      if (bus.ready) seen++;
    end
  endtask

  initial begin
    int seen;
    logic [63:0] m;
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          -1};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  -1};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          -1};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          -1};
    vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          -1};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          -1};
    vecs[6]  = '{1'b0, 32'd50,         32'd3,          32'd16,         32'd2,          20};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          -1};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  -1};
    vecs[9]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  -1};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          -1};
    vecs[11] = '{1'b0, 32'd9,          32'd4,          32'd2,          32'd1,          33};

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0; bus.annul = 1'b0;

    #12;
    chk("reset_quotient", bus.quotient, 32'd0);
    chk("reset_remainder", bus.remainder, 32'd0);
    chk("reset_ready", 32'(bus.ready), 32'd0);
    chk("reset_stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].spur,
            $sformatf("vec%0d", i));
    end

    // Annul in RUN cycle 10: back in IDLE at 11, outputs keep 9/4 result.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd50; bus.b = 32'd3;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.annul = (cyc == 10);
    end
    @(posedge clk); #1;
    bus.annul = 1'b0;
    #3;
    chk("annul_run_stall", 32'(bus.stall_req), 32'd0);
    chk("annul_run_ready", 32'(bus.ready), 32'd0);
    chk("annul_run_quotient", bus.quotient, 32'd2);
    chk("annul_run_remainder", bus.remainder, 32'd1);
    count_ready(40, seen);
    chk("annul_run_no_ready", 32'(seen), 32'd0);

    // Annul in DONE: ready suppressed, result already written stays.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.annul = (cyc == 33);
    end
    #3;
    chk("annul_done_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    #3;
    chk("annul_done_quotient", bus.quotient, 32'd14);
    chk("annul_done_remainder", bus.remainder, 32'd2);
    chk("annul_done_stall", 32'(bus.stall_req), 32'd0);

    // start together with annul in IDLE is ignored.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.annul = 1'b1; bus.a = 32'd9; bus.b = 32'd4;
    #3;
    chk("start_annul_stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.annul = 1'b0;
    #3;
    chk("start_annul_idle", 32'(bus.stall_req), 32'd0);
    count_ready(40, seen);
    chk("start_annul_no_ready", 32'(seen), 32'd0);

    // Asynchronous reset in cycle 15 of a run.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'd50; bus.b = 32'd3;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midreset_quotient", bus.quotient, 32'd0);
    chk("midreset_remainder", bus.remainder, 32'd0);
    chk("midreset_ready", 32'(bus.ready), 32'd0);
    chk("midreset_stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, -1, "post_reset");

    // Random operations checked against the behavioural model.
    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) rb = 32'h0;
      m = model(rs, ra, rb);
      do_op(rs, ra, rb, m[63:32], m[31:0], -1, $sformatf("rand%0d", i));
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the EX stage of the pipelined MIPS core, implementing DIV and DIVU. It consumes the two source operands read from the register file (after forwarding) and produces quotient (LO) and remainder (HI) for the HI/LO write path. While a division is in progress it raises a stall request so that the front of the pipeline holds. It also accepts an annul from the exception/flush logic.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.

- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a division; sampled only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  in  32  dividend (rs value); sampled with start.
- b  in  32  divisor (rt value); sampled with start.
- annul  in  1  flush; abandons any operation in flight.
- stall_req  out  1  holds the IF/ID/EX pipeline registers while high.
- ready  out  1  one-cycle pulse; quotient/remainder are valid and new.
- quotient  out  32  registered quotient (LO).
- remainder  out  32  registered remainder (HI).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 and annul=0, latch |a|, |b|, the operand signs and is_signed.
  - Clear the iteration counter (6-bit) and the 33-bit partial remainder.
  - If b==0, go to DONE; otherwise go to RUN.
  - start with annul=1 is ignored.
- RUN: restoring division, one quotient bit per cycle, MSB first.
  - Shift the partial remainder left by 1 and bring in the next dividend bit.
  - Trial-subtract |b| at 33 bits. If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - After the 32nd iteration, go to DONE.
- Entry to DONE: write the quotient and remainder output registers.
  - Signed mode: negate the quotient if the operand signs differ. The remainder takes the sign of the dividend (negate if a was negative).
  - All negation is 32-bit two's complement with wrap. As a result, 0x80000000 / 0xFFFFFFFF (signed) gives quotient=0x80000000, remainder=0.
  - Divide by zero, either mode: quotient=0xFFFFFFFF, remainder=a as sampled. No sign fix-up is applied.
- DONE: ready=1 for exactly this cycle, then return to IDLE.
- quotient and remainder hold their value until the next DONE entry, through IDLE and through annulled operations.
- start during RUN or DONE is ignored. There is no queueing, and the requester re-issues it.
- annul in RUN or DONE: return to IDLE on the next edge.
  - ready is not pulsed in that cycle; if annul arrives in DONE, ready is forced to 0.
  - Output registers keep their prior contents, except when annul arrives in DONE: the result was already written on entry to DONE and remains.
- stall_req = (IDLE & start & ~annul) | RUN. It is combinational from start and annul, and is 0 in DONE so the pipeline advances with the result.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE; counter and partial remainder clear.
  - quotient=0, remainder=0, ready=0, stall_req=0 as long as start=0.
- Reset mid-operation discards all work, with no ready pulse.
- Cycle numbering: cycle 0 is the cycle where start is sampled in IDLE.
- Normal latency: RUN covers cycles 1-32, DONE is cycle 33. ready=1 and the results are valid in cycle 33. stall_req is high in cycles 0-32.
- Divide-by-zero latency: DONE in cycle 1, stall_req high in cycle 0 only.
- Back-to-back: the earliest new start is cycle 34 (IDLE). start in cycle 33 is ignored.
- annul is sampled every cycle; if asserted in cycle k of RUN, the unit is in IDLE at cycle k+1.

## Test plan
- Unsigned 100 / 7, start at cycle 0 -> stall_req high cycles 0-32; ready only in cycle 33; quotient=14, remainder=2.
- Signed 0xFFFFFFF9 (-7) / 2 -> cycle 33: quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then DIVU on the same operands -> quotient=0x7FFFFFFC, remainder=1.
- Divide by zero, 5 / 0 in both modes -> ready in cycle 1; quotient=0xFFFFFFFF, remainder=5.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0 at cycle 33.
- Annul and ignored start:
  - Complete 9/4 (q=2, r=1), then start 50/3 and assert annul in cycle 10.
  - Expect: IDLE at cycle 11, no ready, outputs still 2/1, stall_req=0.
  - A start asserted in cycle 20 of a fresh run is ignored.
- Reset at cycle 15 of a run -> outputs 0/0 and ready=0 immediately; after reset release, 9/4 completes 33 cycles later with 2/1.
